// File: rtl/decode_stage.sv
// Registered RV32I decode stage: one instruction per valid/ready transfer, decoded
// fields appear one cycle after acceptance, with flush and optional RV32M decode.
module decode_stage #(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b0,
  parameter int ALU_OP_W = 5
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                FLUSH,
  input  logic                IN_VALID,
  output logic                IN_READY,
  input  logic [31:0]         INSTRUCTION,
  input  logic [XLEN-1:0]     IN_PC,
  output logic                OUT_VALID,
  input  logic                OUT_READY,
  output logic [XLEN-1:0]     OUT_PC,
  output logic [4:0]          RS1,
  output logic [4:0]          RS2,
  output logic [4:0]          RD,
  output logic [XLEN-1:0]     IMM,
  output logic [ALU_OP_W-1:0] ALU_OP,
  output logic                USE_IMM,
  output logic                REG_WRITE,
  output logic                MEM_READ,
  output logic                MEM_WRITE,
  output logic                BRANCH,
  output logic                JUMP,
  output logic                ILLEGAL,
  output logic [2:0]          FUNCT3
);

  localparam logic [ALU_OP_W-1:0] ALU_ADD   = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] ALU_SUB   = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] ALU_SLL   = ALU_OP_W'(2);
  localparam logic [ALU_OP_W-1:0] ALU_SLT   = ALU_OP_W'(3);
  localparam logic [ALU_OP_W-1:0] ALU_SLTU  = ALU_OP_W'(4);
  localparam logic [ALU_OP_W-1:0] ALU_XOR   = ALU_OP_W'(5);
  localparam logic [ALU_OP_W-1:0] ALU_SRL   = ALU_OP_W'(6);
  localparam logic [ALU_OP_W-1:0] ALU_SRA   = ALU_OP_W'(7);
  localparam logic [ALU_OP_W-1:0] ALU_OR    = ALU_OP_W'(8);
  localparam logic [ALU_OP_W-1:0] ALU_AND   = ALU_OP_W'(9);
  localparam logic [ALU_OP_W-1:0] ALU_MUL   = ALU_OP_W'(10);
  localparam logic [ALU_OP_W-1:0] ALU_PASSB = ALU_OP_W'(18);

  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_MISC   = 7'h0F;

  function automatic logic [ALU_OP_W-1:0] base_alu(input logic [2:0] f3);
    case (f3)
      3'd0:    return ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = INSTRUCTION[6:0];
  assign funct3 = INSTRUCTION[14:12];
  assign funct7 = INSTRUCTION[31:25];
  assign imm_i  = {{20{INSTRUCTION[31]}}, INSTRUCTION[31:20]};
  assign imm_s  = {{20{INSTRUCTION[31]}}, INSTRUCTION[31:25], INSTRUCTION[11:7]};
  assign imm_b  = {{19{INSTRUCTION[31]}}, INSTRUCTION[31], INSTRUCTION[7],
                   INSTRUCTION[30:25], INSTRUCTION[11:8], 1'b0};
  assign imm_u  = {INSTRUCTION[31:12], 12'b0};
  assign imm_j  = {{11{INSTRUCTION[31]}}, INSTRUCTION[31], INSTRUCTION[19:12],
                   INSTRUCTION[20], INSTRUCTION[30:21], 1'b0};

  logic [4:0]          d_rs1, d_rs2, d_rd;
  logic [31:0]         d_imm;
  logic [ALU_OP_W-1:0] d_alu;
  logic d_use_imm, d_reg_write, d_mem_read, d_mem_write, d_branch, d_jump, d_illegal;

  always_comb begin
    d_rs1 = '0; d_rs2 = '0; d_rd = '0; d_imm = '0; d_alu = ALU_ADD;
    d_use_imm = 1'b0; d_reg_write = 1'b0; d_mem_read = 1'b0; d_mem_write = 1'b0;
    d_branch = 1'b0; d_jump = 1'b0; d_illegal = 1'b0;
    unique case (opcode)
      OPC_LUI: begin
        d_rd = INSTRUCTION[11:7]; d_imm = imm_u; d_alu = ALU_PASSB;
        d_use_imm = 1'b1; d_reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        d_rd = INSTRUCTION[11:7]; d_imm = imm_u; d_use_imm = 1'b1; d_reg_write = 1'b1;
      end
      OPC_JAL: begin
        d_rd = INSTRUCTION[11:7]; d_imm = imm_j; d_use_imm = 1'b1;
        d_jump = 1'b1; d_reg_write = 1'b1;
      end
      OPC_JALR: begin
        d_rs1 = INSTRUCTION[19:15]; d_rd = INSTRUCTION[11:7]; d_imm = imm_i;
        d_use_imm = 1'b1; d_jump = 1'b1; d_reg_write = 1'b1;
      end
      OPC_BRANCH: begin
        d_rs1 = INSTRUCTION[19:15]; d_rs2 = INSTRUCTION[24:20]; d_imm = imm_b;
        d_alu = ALU_SUB; d_branch = 1'b1;
        d_illegal = (funct3 == 3'd2) || (funct3 == 3'd3);
      end
      OPC_LOAD: begin
        d_rs1 = INSTRUCTION[19:15]; d_rd = INSTRUCTION[11:7]; d_imm = imm_i;
        d_use_imm = 1'b1; d_mem_read = 1'b1; d_reg_write = 1'b1;
        d_illegal = (funct3 == 3'd3) || (funct3 >= 3'd6);
      end
      OPC_STORE: begin
        d_rs1 = INSTRUCTION[19:15]; d_rs2 = INSTRUCTION[24:20]; d_imm = imm_s;
        d_use_imm = 1'b1; d_mem_write = 1'b1;
        d_illegal = funct3 > 3'd2;
      end
      OPC_OPIMM: begin
        d_rs1 = INSTRUCTION[19:15]; d_rd = INSTRUCTION[11:7]; d_imm = imm_i;
        d_use_imm = 1'b1; d_reg_write = 1'b1; d_alu = base_alu(funct3);
        if (funct3 == 3'd5 && funct7 == 7'h20) d_alu = ALU_SRA;
        // Shift-immediates reuse the top I-immediate bits as funct7.
        d_illegal = (funct3 == 3'd1 && funct7 != 7'h00) ||
                    (funct3 == 3'd5 && funct7 != 7'h00 && funct7 != 7'h20);
      end
      OPC_OP: begin
        d_rs1 = INSTRUCTION[19:15]; d_rs2 = INSTRUCTION[24:20]; d_rd = INSTRUCTION[11:7];
        d_reg_write = 1'b1;
        case (funct7)
          7'h00: d_alu = base_alu(funct3);
          7'h20: begin
            if (funct3 == 3'd0)      d_alu = ALU_SUB;
            else if (funct3 == 3'd5) d_alu = ALU_SRA;
            else                     d_illegal = 1'b1;
          end
          7'h01: begin
            d_alu = ALU_MUL + ALU_OP_W'(funct3);
            d_illegal = !ENABLE_M;
          end
          default: d_illegal = 1'b1;
        endcase
      end
      OPC_MISC: begin
        // FENCE retires as a NOP: no fields, no side effects.
      end
      default: d_illegal = 1'b1;
    endcase
    if (d_illegal) begin
      d_reg_write = 1'b0; d_mem_read = 1'b0; d_mem_write = 1'b0;
      d_branch = 1'b0; d_jump = 1'b0;
    end
    if (d_rd == 5'd0) d_reg_write = 1'b0;
  end

  // Handshake: a transfer happens on an edge where valid && ready on that side.
  // IN_READY depends only on OUT_VALID/OUT_READY; FLUSH drops both held and incoming.
  logic load_en;
  assign IN_READY = !OUT_VALID || OUT_READY;
  assign load_en  = IN_VALID && IN_READY;

  always_ff @(posedge CLK) begin
    if (RST) begin
      OUT_VALID <= 1'b0; OUT_PC <= '0; RS1 <= '0; RS2 <= '0; RD <= '0; IMM <= '0;
      ALU_OP <= '0; USE_IMM <= 1'b0; REG_WRITE <= 1'b0; MEM_READ <= 1'b0;
      MEM_WRITE <= 1'b0; BRANCH <= 1'b0; JUMP <= 1'b0; ILLEGAL <= 1'b0; FUNCT3 <= '0;
    end else if (FLUSH) begin
      OUT_VALID <= 1'b0;
    end else if (load_en) begin
      OUT_VALID <= 1'b1; OUT_PC <= IN_PC; RS1 <= d_rs1; RS2 <= d_rs2; RD <= d_rd;
      IMM <= XLEN'($signed(d_imm)); ALU_OP <= d_alu; USE_IMM <= d_use_imm;
      REG_WRITE <= d_reg_write; MEM_READ <= d_mem_read; MEM_WRITE <= d_mem_write;
      BRANCH <= d_branch; JUMP <= d_jump; ILLEGAL <= d_illegal; FUNCT3 <= funct3;
    end else if (OUT_READY) begin
      OUT_VALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: two instances (M off / M on) share stimulus; outputs are
// compared to a behavioural decode model each cycle and transfers to an expected queue.
module tb_decode_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic [4:0]  alu;
    logic use_imm, reg_write, mem_read, mem_write, branch, jump, illegal;
    logic [2:0]  funct3;
  } dec_t;
  localparam int W = $bits(dec_t);

  logic CLK, RST, FLUSH, IN_VALID, OUT_READY;
  logic [31:0] INSTRUCTION, IN_PC;

  logic rdy0, vld0, rdy1, vld1;
  logic [31:0] pc0, imm0, pc1, imm1;
  logic [4:0] rs1_0, rs2_0, rd0, alu0, rs1_1, rs2_1, rd1, alu1;
  logic ui0, rw0, mr0, mw0, br0, jp0, il0, ui1, rw1, mr1, mw1, br1, jp1, il1;
  logic [2:0] f3_0, f3_1;
  dec_t obs0, obs1;

  assign obs0 = {pc0, rs1_0, rs2_0, rd0, imm0, alu0, ui0, rw0, mr0, mw0, br0, jp0, il0, f3_0};
  assign obs1 = {pc1, rs1_1, rs2_1, rd1, imm1, alu1, ui1, rw1, mr1, mw1, br1, jp1, il1, f3_1};

  decode_stage #(.XLEN(32), .ENABLE_M(1'b0), .ALU_OP_W(5)) u_dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .IN_VALID(IN_VALID), .IN_READY(rdy0),
    .INSTRUCTION(INSTRUCTION), .IN_PC(IN_PC), .OUT_VALID(vld0), .OUT_READY(OUT_READY),
    .OUT_PC(pc0), .RS1(rs1_0), .RS2(rs2_0), .RD(rd0), .IMM(imm0), .ALU_OP(alu0),
    .USE_IMM(ui0), .REG_WRITE(rw0), .MEM_READ(mr0), .MEM_WRITE(mw0), .BRANCH(br0),
    .JUMP(jp0), .ILLEGAL(il0), .FUNCT3(f3_0));

  decode_stage #(.XLEN(32), .ENABLE_M(1'b1), .ALU_OP_W(5)) u_dut_m (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .IN_VALID(IN_VALID), .IN_READY(rdy1),
    .INSTRUCTION(INSTRUCTION), .IN_PC(IN_PC), .OUT_VALID(vld1), .OUT_READY(OUT_READY),
    .OUT_PC(pc1), .RS1(rs1_1), .RS2(rs2_1), .RD(rd1), .IMM(imm1), .ALU_OP(alu1),
    .USE_IMM(ui1), .REG_WRITE(rw1), .MEM_READ(mr1), .MEM_WRITE(mw1), .BRANCH(br1),
    .JUMP(jp1), .ILLEGAL(il1), .FUNCT3(f3_1));

  // Clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic m_valid = 1'b0;
  dec_t m0 = '0, m1 = '0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference decode straight from the ISA encoding rules, in integer arithmetic.
  function automatic dec_t ref_decode(input logic [31:0] ins, input logic [31:0] pc, input bit en_m);
    dec_t d;
    int s, imm_i, imm_s, imm_b, imm_u, imm_j;
    int base_map[8];
    logic [6:0] op, f7;
    logic [2:0] f3;
    bit ill, has_rs1, has_rs2, has_rd;
    base_map = '{0, 2, 3, 4, 5, 6, 8, 9};
    d = '0; ill = 0; has_rs1 = 0; has_rs2 = 0; has_rd = 0;
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    s = $signed(ins);
    imm_i = s >>> 20;
    imm_s = ((s >>> 25) <<< 5) | int'(ins[11:7]);
    imm_b = ((s >>> 31) <<< 12) | (int'(ins[7]) << 11) | (int'(ins[30:25]) << 5) | (int'(ins[11:8]) << 1);
    imm_u = int'(ins & 32'hFFFFF000);
    imm_j = ((s >>> 31) <<< 20) | (int'(ins[19:12]) << 12) | (int'(ins[20]) << 11) | (int'(ins[30:21]) << 1);
    d.pc = pc; d.funct3 = f3;
    case (op)
      7'h37: begin has_rd = 1; d.imm = 32'(imm_u); d.alu = 18; d.use_imm = 1; d.reg_write = 1; end
      7'h17: begin has_rd = 1; d.imm = 32'(imm_u); d.use_imm = 1; d.reg_write = 1; end
      7'h6F: begin has_rd = 1; d.imm = 32'(imm_j); d.use_imm = 1; d.jump = 1; d.reg_write = 1; end
      7'h67: begin has_rs1 = 1; has_rd = 1; d.imm = 32'(imm_i); d.use_imm = 1; d.jump = 1; d.reg_write = 1; end
      7'h63: begin has_rs1 = 1; has_rs2 = 1; d.imm = 32'(imm_b); d.alu = 1; d.branch = 1; ill = (f3 == 2 || f3 == 3); end
      7'h03: begin has_rs1 = 1; has_rd = 1; d.imm = 32'(imm_i); d.use_imm = 1; d.mem_read = 1; d.reg_write = 1;
                   ill = (f3 == 3 || f3 == 6 || f3 == 7); end
      7'h23: begin has_rs1 = 1; has_rs2 = 1; d.imm = 32'(imm_s); d.use_imm = 1; d.mem_write = 1; ill = (f3 > 2); end
      7'h13: begin
        has_rs1 = 1; has_rd = 1; d.imm = 32'(imm_i); d.use_imm = 1; d.reg_write = 1;
        d.alu = 5'(base_map[f3]);
        if (f3 == 5 && f7 == 7'h20) d.alu = 7;
        if (f3 == 1) ill = (f7 != 0);
        if (f3 == 5) ill = !(f7 == 0 || f7 == 7'h20);
      end
      7'h33: begin
        has_rs1 = 1; has_rs2 = 1; has_rd = 1; d.reg_write = 1;
        if (f7 == 0) d.alu = 5'(base_map[f3]);
        else if (f7 == 7'h20) begin
          if (f3 == 0) d.alu = 1; else if (f3 == 5) d.alu = 7; else ill = 1;
        end else if (f7 == 7'h01) begin
          d.alu = 5'(10 + int'(f3)); ill = !en_m;
        end else ill = 1;
      end
      7'h0F: ;
      default: ill = 1;
    endcase
    if (has_rs1) d.rs1 = ins[19:15];
    if (has_rs2) d.rs2 = ins[24:20];
    if (has_rd)  d.rd  = ins[11:7];
    d.illegal = ill;
    if (ill) begin d.reg_write = 0; d.mem_read = 0; d.mem_write = 0; d.branch = 0; d.jump = 0; end
    if (d.rd == 0) d.reg_write = 0;
    return d;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops[12];
    logic [31:0] ins;
    int k;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73, 7'h00};
    ins = $urandom;
    k = $urandom_range(0, 11);
    ins[6:0] = (k == 11) ? 7'($urandom) : ops[k];
    k = $urandom_range(0, 4);
    if (k == 0) ins[31:25] = 7'h00;
    else if (k == 1) ins[31:25] = 7'h20;
    else if (k == 2) ins[31:25] = 7'h01;
    return ins;
  endfunction

  // Driver: one clock cycle with the given inputs, then model update and checks.
  task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic ordy, input logic fl, input logic rs);
    logic acc;
    IN_VALID = v; INSTRUCTION = ins; IN_PC = pc; OUT_READY = ordy; FLUSH = fl; RST = rs;
    #1;
    if (!rs) begin
      chk("in_ready0", rdy0, !m_valid || ordy);
      chk("in_ready1", rdy1, !m_valid || ordy);
    end
    acc = v && (!m_valid || ordy) && !fl && !rs;
    if (rs || fl) exp_q.delete();
    else if (m_valid && ordy) begin
      chk("sb_depth", exp_q.size(), 1);
      if (exp_q.size() != 0) chk("sb_xfer", obs0, exp_q.pop_front());
    end
    @(posedge CLK);
    if (rs) begin m_valid = 0; m0 = '0; m1 = '0; end
    else if (fl) m_valid = 0;
    else if (acc) begin
      m_valid = 1; m0 = ref_decode(ins, pc, 1'b0); m1 = ref_decode(ins, pc, 1'b1);
      exp_q.push_back(m0);
    end else if (ordy) m_valid = 0;
    @(negedge CLK);
    chk("out_valid0", vld0, m_valid);
    chk("out_valid1", vld1, m_valid);
    chk("outputs0", obs0, m0);
    chk("outputs1", obs1, m1);
  endtask

  initial begin
    IN_VALID = 0; INSTRUCTION = '0; IN_PC = '0; OUT_READY = 1; FLUSH = 0; RST = 1;
    cycle(0, 0, 0, 1, 0, 1);
    cycle(0, 0, 0, 1, 0, 1);
    chk("rst_outputs", obs0, '0);

    cycle(1, 32'hFFB10093, 32'h100, 1, 0, 0);
    chk("addi_valid", vld0, 1); chk("addi_rs1", rs1_0, 2); chk("addi_rd", rd0, 1);
    chk("addi_imm", imm0, 32'hFFFFFFFB); chk("addi_alu", alu0, 0);
    chk("addi_use_imm", ui0, 1); chk("addi_rw", rw0, 1); chk("addi_ill", il0, 0);

    cycle(1, 32'h00532423, 32'h104, 1, 0, 0);
    chk("sw_rs1", rs1_0, 6); chk("sw_rs2", rs2_0, 5); chk("sw_rd", rd0, 0);
    chk("sw_imm", imm0, 32'h8); chk("sw_mw", mw0, 1); chk("sw_rw", rw0, 0); chk("sw_f3", f3_0, 2);

    cycle(1, 32'hFE000EE3, 32'h108, 1, 0, 0);
    chk("beq_imm", imm0, 32'hFFFFFFFC); chk("beq_br", br0, 1); chk("beq_alu", alu0, 1);
    chk("beq_valid", vld0, 1);
    cycle(1, 32'h123452B7, 32'h10C, 1, 0, 0);
    chk("lui_imm", imm0, 32'h12345000); chk("lui_alu", alu0, 18); chk("lui_rd", rd0, 5);
    chk("lui_valid", vld0, 1);

    cycle(1, 32'h022081B3, 32'h110, 1, 0, 0);
    chk("mul_nom_ill", il0, 1); chk("mul_nom_rw", rw0, 0);
    chk("mul_m_alu", alu1, 10); chk("mul_m_rw", rw1, 1); chk("mul_m_ill", il1, 0);

    // Stall with a pending addi x2,x0,1, then release.
    for (int i = 0; i < 3; i++) begin
      cycle(1, 32'h00100113, 32'h114, 0, 0, 0);
      chk("stall_in_ready", rdy0, 0); chk("stall_pc", pc0, 32'h110);
    end
    cycle(1, 32'h00100113, 32'h114, 1, 0, 0);
    chk("release_pc", pc0, 32'h114); chk("release_rd", rd0, 2);
    cycle(0, 0, 0, 1, 0, 0);
    chk("drain_valid", vld0, 0);

    // Flush with a held instruction and a same-cycle input.
    cycle(1, 32'h00100113, 32'h200, 0, 0, 0);
    cycle(1, 32'h123452B7, 32'h204, 0, 1, 0);
    chk("flush_valid", vld0, 0); chk("flush_pc", pc0, 32'h200);

    // Reset during a stall.
    cycle(1, 32'h00532423, 32'h300, 0, 0, 0);
    cycle(1, 32'hFFB10093, 32'h304, 0, 0, 0);
    cycle(1, 32'hFFB10093, 32'h304, 0, 0, 1);
    chk("rst_stall_valid", vld0, 0); chk("rst_stall_out", obs0, '0);

    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom_range(0, 3) != 0,
            $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0);
    end
    chk("sb_left", exp_q.size(), m_valid ? 1 : 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
